// File: rtl/seq_divider_8.sv
// seq_divider_8: iterative signed radix-2 restoring divider.
// Works on operand magnitudes, one quotient bit per clock, then applies signs
// and resolves the divide-by-zero and most-negative/-1 cases in a final step.
// Results truncate toward zero, matching Verilog / and %.
module seq_divider_8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    localparam logic [WIDTH-1:0] ZERO     = '0;
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] raw_dividend;
    logic             sq;
    logic             sr;
    logic             zero_div;
    logic             ovf_case;

    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;

    // Magnitudes, one restoring step, and sign-corrected final values.
    always_comb begin
        dividend_mag = dividend[WIDTH-1] ? (ZERO - dividend) : dividend;
        divisor_mag  = divisor[WIDTH-1]  ? (ZERO - divisor)  : divisor;
        shifted      = {rem, q[WIDTH-1]};
        trial        = shifted - {2'b00, dvs_mag};
        q_final      = sq ? (ZERO - q) : q;
        r_final      = sr ? (ZERO - rem[WIDTH-1:0]) : rem[WIDTH-1:0];
    end

    // Busy covers the iteration cycles plus the fix-up cycle.
    assign busy = (state == RUN) || (state == FIX);

    // Control sequencing and the shift/subtract datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            count        <= '0;
            rem          <= '0;
            q            <= '0;
            dvs_mag      <= '0;
            raw_dividend <= '0;
            sq           <= 1'b0;
            sr           <= 1'b0;
            zero_div     <= 1'b0;
            ovf_case     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= RUN;
                        count        <= '0;
                        rem          <= '0;
                        q            <= dividend_mag;
                        dvs_mag      <= divisor_mag;
                        raw_dividend <= dividend;
                        sq           <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        sr           <= dividend[WIDTH-1];
                        zero_div     <= (divisor == ZERO);
                        ovf_case     <= (dividend == MOST_NEG) && (divisor == ALL_ONES);
                    end
                end
                RUN: begin
                    if (trial[WIDTH+1]) begin
                        rem <= shifted[WIDTH:0];
                        q   <= {q[WIDTH-2:0], 1'b0};
                    end else begin
                        rem <= trial[WIDTH:0];
                        q   <= {q[WIDTH-2:0], 1'b1};
                    end
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Result registers, written only on the fix-up edge; done pulses once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == FIX) begin
                done <= 1'b1;
                if (zero_div) begin
                    quotient    <= ALL_ONES;
                    remainder   <= raw_dividend;
                    div_by_zero <= 1'b1;
                    overflow    <= 1'b0;
                end else if (ovf_case) begin
                    quotient    <= MOST_NEG;
                    remainder   <= ZERO;
                    div_by_zero <= 1'b0;
                    overflow    <= 1'b1;
                end else begin
                    quotient    <= q_final;
                    remainder   <= r_final;
                    div_by_zero <= 1'b0;
                    overflow    <= 1'b0;
                end
            end
        end
    end

endmodule
